// File: rtl/vswitch_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// vswitch_dispatch_pkg
// Shared types and helpers for the vSwitch AXI4-Stream dispatcher.
//   dispatch_state_e : dispatcher FSM states (IDLE, DECIDE, FWD, DROP)
//   id_in_range()    : true when a vSwitch ID addresses an existing channel
//   KEEP_W / SEL_W   : tkeep and selector widths for the default build;
//                      they also serve as default parameter values.
// ---------------------------------------------------------------------------
package vswitch_dispatch_pkg;

  localparam int DEF_DATA_W = 256;
  localparam int KEEP_W     = DEF_DATA_W / 8;
  localparam int SEL_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_FWD    = 2'd2,
    ST_DROP   = 2'd3
  } dispatch_state_e;

  function automatic logic id_in_range(input int id, input int num_vsw);
    return (id < num_vsw);
  endfunction

endpackage

// File: rtl/vswitch_axis_out_reg.sv
// ---------------------------------------------------------------------------
// vswitch_axis_out_reg
// Single-entry registered AXI4-Stream output stage for one vSwitch channel.
//   clk, rst           : clock, synchronous active-high reset
//   load               : capture load_* into the output register this edge
//   load_data/keep/user/last : beat to capture
//   tdata/tkeep/tuser/tlast/tvalid : registered AXIS master outputs
//   tready             : downstream ready
// The parent only asserts load when the stage is empty or draining
// (~tvalid | tready), so a held beat is never overwritten.
// ---------------------------------------------------------------------------
module vswitch_axis_out_reg
  import vswitch_dispatch_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int TKEEP_W = DATA_W / 8,
  parameter int USER_W  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [TKEEP_W-1:0] load_keep,
  input  logic [USER_W-1:0]  load_user,
  input  logic               load_last,
  output logic [DATA_W-1:0]  tdata,
  output logic [TKEEP_W-1:0] tkeep,
  output logic [USER_W-1:0]  tuser,
  output logic               tlast,
  output logic               tvalid,
  input  logic               tready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tdata  <= '0;
      tkeep  <= '0;
      tuser  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      // Load wins over drain: a same-cycle drain + load gives back-to-back beats.
      tdata  <= load_data;
      tkeep  <= load_keep;
      tuser  <= load_user;
      tlast  <= load_last;
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/vswitch_axis_dispatch.sv
// ---------------------------------------------------------------------------
// vswitch_axis_dispatch
// Steers whole AXI4-Stream packets from the IvSI to one of NUM_VSW vSwitch
// channels, selected by the vSwitch ID in tuser on the first beat.
//   axis_aclk, axis_reset : clock, synchronous active-high reset
//   s_axis_*              : ingress stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   m_axis_*              : NUM_VSW flattened egress streams, channel i in slice i
//   pkt_cnt               : per-channel count of fully forwarded packets
//   drop_cnt              : count of dropped packets
// Build option: define VSWITCH_DISPATCH_DROP_EN to drop packets whose ID is
// >= NUM_VSW. Without it those packets go to channel 0 and drop_cnt is 0.
//
// Handshake: a beat transfers on any interface in a cycle where tvalid and
// tready are both 1 at the rising edge; a valid beat holds stable until then.
// ---------------------------------------------------------------------------
module vswitch_axis_dispatch
  import vswitch_dispatch_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = DEF_DATA_W,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_VSW            = 4,
  parameter int VSW_ID_LSB         = 64,
  parameter int VSW_ID_WIDTH       = SEL_W,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                    axis_aclk,
  input  logic                                    axis_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]          s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic                                    s_axis_tlast,
  output logic [NUM_VSW*C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [NUM_VSW*C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [NUM_VSW*C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [NUM_VSW-1:0]                      m_axis_tvalid,
  input  logic [NUM_VSW-1:0]                      m_axis_tready,
  output logic [NUM_VSW-1:0]                      m_axis_tlast,
  output logic [NUM_VSW*CNT_WIDTH-1:0]            pkt_cnt,
  output logic [CNT_WIDTH-1:0]                    drop_cnt
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  dispatch_state_e         state_q;
  logic [VSW_ID_WIDTH-1:0] sel_q;
  logic [VSW_ID_WIDTH-1:0] id_field;
  logic [NUM_VSW-1:0]      sel_hit;
  logic [NUM_VSW-1:0]      load;
  logic                    sel_room;
  logic                    accept;
  logic                    pkt_done;

  assign id_field = s_axis_tuser[VSW_ID_LSB +: VSW_ID_WIDTH];

  // One-hot decode of the selected channel; avoids indexing by a selector
  // that may be wider than the channel count.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NUM_VSW; i++) begin
      sel_hit[i] = (int'(sel_q) == i);
    end
  end

  // Selected channel can take a beat when empty or draining this cycle.
  assign sel_room = |(sel_hit & (~m_axis_tvalid | m_axis_tready));

  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      ST_FWD:  s_axis_tready = sel_room;
`ifdef VSWITCH_DISPATCH_DROP_EN
      ST_DROP: s_axis_tready = 1'b1;
`endif
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign load     = (state_q == ST_FWD && accept) ? sel_hit : '0;
  assign pkt_done = (state_q == ST_FWD) && accept && s_axis_tlast;

  // Dispatcher FSM. DECIDE spends one cycle latching the ID so the first
  // beat is never consumed before its destination is known.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_axis_tvalid) state_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (id_in_range(int'(id_field), NUM_VSW)) begin
            sel_q   <= id_field;
            state_q <= ST_FWD;
          end else begin
`ifdef VSWITCH_DISPATCH_DROP_EN
            sel_q   <= id_field;
            state_q <= ST_DROP;
`else
            sel_q   <= '0;
            state_q <= ST_FWD;
`endif
          end
        end
        ST_FWD: begin
          if (accept && s_axis_tlast) state_q <= ST_IDLE;
        end
`ifdef VSWITCH_DISPATCH_DROP_EN
        ST_DROP: begin
          if (accept && s_axis_tlast) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_VSW; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] pkt_cnt_q;

    always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
        pkt_cnt_q <= '0;
      end else if (pkt_done && sel_hit[i]) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
      end
    end

    assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q;

    vswitch_axis_out_reg #(
      .DATA_W  (C_AXIS_DATA_WIDTH),
      .TKEEP_W (KW),
      .USER_W  (C_AXIS_TUSER_WIDTH)
    ) u_out (
      .clk       (axis_aclk),
      .rst       (axis_reset),
      .load      (load[i]),
      .load_data (s_axis_tdata),
      .load_keep (s_axis_tkeep),
      .load_user (s_axis_tuser),
      .load_last (s_axis_tlast),
      .tdata     (m_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH]),
      .tkeep     (m_axis_tkeep[i*KW +: KW]),
      .tuser     (m_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH]),
      .tlast     (m_axis_tlast[i]),
      .tvalid    (m_axis_tvalid[i]),
      .tready    (m_axis_tready[i])
    );
  end

`ifdef VSWITCH_DISPATCH_DROP_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      drop_cnt_q <= '0;
    end else if (state_q == ST_DROP && accept && s_axis_tlast) begin
      drop_cnt_q <= drop_cnt_q + CNT_ONE;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_vswitch_axis_dispatch.sv
// ---------------------------------------------------------------------------
// tb_vswitch_axis_dispatch
// Self-checking bench for vswitch_axis_dispatch (4 channels, 64-bit data).
// A packet-level model routes every accepted ingress beat to an expected
// queue per channel (or to the drop count) and tracks expected counters.
// Honours VSWITCH_DISPATCH_DROP_EN when building expectations.
// ---------------------------------------------------------------------------
module tb_vswitch_axis_dispatch;

  localparam int DW     = 64;
  localparam int KW     = DW / 8;
  localparam int UW     = 128;
  localparam int NV     = 4;
  localparam int CW     = 32;
  localparam int ID_LSB = 64;
  localparam int BW     = 1 + UW + KW + DW;
`ifdef VSWITCH_DISPATCH_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic axis_reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic [DW-1:0]    s_axis_tdata = '0;
  logic [KW-1:0]    s_axis_tkeep = '0;
  logic [UW-1:0]    s_axis_tuser = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic             s_axis_tlast = 1'b0;
  logic [NV*DW-1:0] m_axis_tdata;
  logic [NV*KW-1:0] m_axis_tkeep;
  logic [NV*UW-1:0] m_axis_tuser;
  logic [NV-1:0]    m_axis_tvalid;
  logic [NV-1:0]    m_axis_tready = '1;
  logic [NV-1:0]    m_axis_tlast;
  logic [NV*CW-1:0] pkt_cnt;
  logic [CW-1:0]    drop_cnt;

  vswitch_axis_dispatch #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_VSW            (NV),
    .VSW_ID_LSB         (ID_LSB),
    .VSW_ID_WIDTH       (4),
    .CNT_WIDTH          (CW)
  ) dut (
    .axis_aclk     (clk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[NV][$];
  logic [CW-1:0] exp_pkt[NV];
  logic [CW-1:0] exp_drop;
  int checks = 0;
  int errors = 0;

  logic          rand_mode = 1'b0;
  logic [NV-1:0] ready_cfg = '1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] beat_of(input int i);
    return {m_axis_tlast[i], m_axis_tuser[i*UW +: UW], m_axis_tkeep[i*KW +: KW],
            m_axis_tdata[i*DW +: DW]};
  endfunction

  function automatic int queued_total();
    int n = 0;
    for (int i = 0; i < NV; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NV; i++) begin
      exp_q[i].delete();
      exp_pkt[i] = '0;
    end
    exp_drop = '0;
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < NV; i++)
      check_eq($sformatf("%s_pkt_cnt%0d", tag, i), pkt_cnt[i*CW +: CW], exp_pkt[i]);
    check_eq($sformatf("%s_drop_cnt", tag), drop_cnt, exp_drop);
  endtask

  // ---------------- egress ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rand_mode ? NV'($urandom) : ready_cfg;
  end

  // ---------------- egress monitor ----------------
  logic [BW-1:0] prev_beat[NV];
  bit            prev_hold[NV];

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      if (axis_reset) begin
        prev_hold[i] = 1'b0;
      end else begin
        if (prev_hold[i]) begin
          check_eq($sformatf("ch%0d_hold_valid", i), m_axis_tvalid[i], 1'b1);
          check_eq($sformatf("ch%0d_hold_stable", i), beat_of(i), prev_beat[i]);
        end
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          check_eq($sformatf("ch%0d_beat_expected", i), exp_q[i].size() != 0, 1'b1);
          if (exp_q[i].size() != 0) begin
            logic [BW-1:0] e;
            e = exp_q[i].pop_front();
            check_eq($sformatf("ch%0d_beat", i), beat_of(i), e);
          end
        end
        prev_hold[i] = m_axis_tvalid[i] && !m_axis_tready[i];
        prev_beat[i] = beat_of(i);
      end
    end
  end

  // ---------------- ingress driver + model ----------------
  // Called at posedge+1; returns at posedge+1 with tvalid low.
  task automatic send_pkt(input int id, input int nbeats, input int abort_after,
                          output int first_cyc, output int last_cyc);
    int target;
    bit hs;
    int waits;
    first_cyc = 0;
    last_cyc  = 0;
    target = (id < NV) ? id : (DROP_EN ? -1 : 0);
    for (int b = 0; b < nbeats; b++) begin
      s_axis_tdata = {$urandom, $urandom};
      s_axis_tkeep = KW'($urandom);
      s_axis_tuser = {$urandom, $urandom, $urandom, $urandom};
      if (b == 0) s_axis_tuser[ID_LSB +: 4] = 4'(id);
      s_axis_tlast  = (b == nbeats - 1);
      s_axis_tvalid = 1'b1;
      hs = 1'b0;
      waits = 0;
      while (!hs && waits < 200) begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk);
        #1;
        waits++;
      end
      if (!hs) begin
        check_eq("ingress_accept_timeout", hs, 1'b1);
        break;
      end
      if (b == 0) first_cyc = cyc;
      last_cyc = cyc;
      if (target >= 0)
        exp_q[target].push_back({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata});
      if (s_axis_tlast) begin
        if (target >= 0) exp_pkt[target] = exp_pkt[target] + 1'b1;
        else             exp_drop = exp_drop + 1'b1;
      end
      if (abort_after == b + 1) break;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (queued_total() > 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_drain"}, queued_total(), 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_idle_valid"}, m_axis_tvalid, '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int f, l, start, lat, prev_l;

  initial begin
    clear_model();
    axis_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    axis_reset = 1'b0;

    // Reset state
    check_eq("rst_tvalid", m_axis_tvalid, '0);
    check_eq("rst_tlast", m_axis_tlast, '0);
    check_eq("rst_s_tready", s_axis_tready, 1'b0);
    check_eq("rst_tdata", m_axis_tdata, '0);
    check_eq("rst_tkeep", m_axis_tkeep, '0);
    check_eq("rst_tuser", m_axis_tuser[255:0], '0);
    check_counters("rst");

    // 3-beat packet to ID 2, all ready: first output beat 3 cycles after tvalid
    start = cyc;
    fork
      send_pkt(2, 3, 0, f, l);
      begin
        lat = 0;
        while (lat < 20) begin
          @(posedge clk);
          #2;
          lat++;
          if (m_axis_tvalid[2]) break;
        end
        check_eq("t1_first_beat_latency", lat, 3);
        check_eq("t1_other_valid", m_axis_tvalid & 4'b1011, '0);
      end
    join
    check_eq("t1_accept_latency", f - start, 3);
    check_eq("t1_streaming", l - f, 2);
    wait_drain("t1");
    check_counters("t1");

    // 4-beat packet to ID 1 with channel 1 stalled
    ready_cfg = 4'b1101;
    @(posedge clk);
    #1;
    fork
      send_pkt(1, 4, 0, f, l);
      begin
        lat = 0;
        while (!m_axis_tvalid[1] && lat < 20) begin
          @(posedge clk);
          #2;
          lat++;
        end
        @(negedge clk);
        check_eq("t2_stall_s_tready", s_axis_tready, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        ready_cfg = '1;
      end
    join
    check_eq("t2_stall_delayed", (l - f) > 3, 1'b1);
    wait_drain("t2");
    check_counters("t2");

    // Back-to-back single-beat packets, 2-cycle bubble between them
    for (int id = 0; id < NV; id++) begin
      send_pkt(id, 1, 0, f, l);
      if (id > 0) check_eq($sformatf("t3_bubble_%0d", id), f - prev_l, 3);
      prev_l = l;
    end
    wait_drain("t3");
    check_counters("t3");

    // Out-of-range ID 7: dropped, or forwarded to channel 0 without the drop option
    send_pkt(7, 2, 0, f, l);
    check_eq("t4_consecutive_beats", l - f, 1);
    wait_drain("t4");
    check_counters("t4");

    // Reset mid-packet after beat 2 of 5, then a clean packet to ID 3
    send_pkt(2, 5, 2, f, l);
    axis_reset = 1'b1;
    @(posedge clk);
    #1;
    axis_reset = 1'b0;
    clear_model();
    check_eq("t5_rst_tvalid", m_axis_tvalid, '0);
    check_eq("t5_rst_s_tready", s_axis_tready, 1'b0);
    check_counters("t5_rst");
    send_pkt(3, 3, 0, f, l);
    wait_drain("t5");
    check_counters("t5");

    // Counter wrap on channel 0
    force dut.g_ch[0].pkt_cnt_q = '1;
    @(posedge clk);
    #1;
    release dut.g_ch[0].pkt_cnt_q;
    exp_pkt[0] = '1;
    check_counters("t6_preload");
    send_pkt(0, 2, 0, f, l);
    wait_drain("t6");
    check_counters("t6_wrap");

    // Randomized traffic with random egress back-pressure
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_pkt($urandom_range(0, 6), $urandom_range(1, 5), 0, f, l);
    end
    rand_mode = 1'b0;
    ready_cfg = '1;
    @(posedge clk);
    #1;
    wait_drain("rand");
    check_counters("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
